aes_key_sync_sched: RTL and testbench

Controller that sequences key/sync delivery to the AES encryptor core for counter-mode operation. It accepts one configuration (key, initial sync, block count) through a valid/rdy slave port. It then issues one key/sync pair per AES block on a valid/rdy master port, incrementing the counter field of the sync each time a block is accepted. It sits between the software/config layer and the dvr key/sync input of the encryptor.

---
 rtl/aes_key_sync_sched.sv | 125 ++++++++++++
 tb/tb_aes_key_sync_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sync_sched.sv
// Sequences one key/sync pair per AES block for counter mode, bumping the sync counter field per accepted block.
// Latency: config accepted at edge N gives out_valid in cycle N+1; one block per cycle; done one cycle after the last handshake.
// Backpressure: out_* held stable while out_valid & !out_rdy; cfg_rdy low for the whole run until the done cycle has passed.
module aes_key_sync_sched #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int CNT_WIDTH           = 32,
    parameter int NUM_BLOCKS_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0]   cfg_key,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0]   cfg_sync,
    input  logic [NUM_BLOCKS_WIDTH-1:0]        cfg_num_blocks,
    input  logic                               cfg_valid,
    output logic                               cfg_rdy,
    input  logic                               abort,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]   out_key,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]   out_sync,
    output logic                               out_valid,
    input  logic                               out_rdy,
    output logic                               done,
    output logic                               aborted,
    output logic                               cnt_wrap,
    output logic [NUM_BLOCKS_WIDTH-1:0]        blocks_sent
);
    localparam int W = DATA_WIDTH_IN_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [W-1:0]                key_reg;
    logic [W-1:0]                sync_reg;
    logic [W-1:0]                sync_inc;
    logic [NUM_BLOCKS_WIDTH-1:0] remaining;
    logic [NUM_BLOCKS_WIDTH-1:0] sent_reg;
    logic                        aborted_reg;
    logic                        wrap_reg;
    logic                        accept;
    logic                        hs;
    logic                        last;

    // Handshake qualifiers are all decoded from state so cfg_rdy reads 1 straight out of reset.
    assign cfg_rdy   = (state == IDLE);
    assign out_valid = (state == ISSUE);
    assign done      = (state == DONE);
    assign accept    = cfg_valid && cfg_rdy;
    assign hs        = out_valid && out_rdy;
    assign last      = (remaining == NUM_BLOCKS_WIDTH'(1));

    assign out_key     = key_reg;
    assign out_sync    = sync_reg;
    assign aborted     = aborted_reg;
    assign cnt_wrap    = wrap_reg;
    assign blocks_sent = sent_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero-length run goes straight to DONE; abort or last handshake ends ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cfg_num_blocks == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if ((hs && last) || abort) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next sync: only the low counter field advances (mod 2^CNT_WIDTH), nonce bits pass through.
    always_comb begin
        sync_inc                  = sync_reg;
        sync_inc[CNT_WIDTH-1:0]   = sync_reg[CNT_WIDTH-1:0] + CNT_WIDTH'(1);
    end

    // Run datapath: latch config on accept, advance per handshake, record abort and counter wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg     <= '0;
            sync_reg    <= '0;
            remaining   <= '0;
            sent_reg    <= '0;
            aborted_reg <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (accept) begin
                key_reg     <= cfg_key;
                sync_reg    <= cfg_sync;
                remaining   <= cfg_num_blocks;
                sent_reg    <= '0;
                aborted_reg <= 1'b0;
            end
            if (hs) begin
                sync_reg  <= sync_inc;
                remaining <= remaining - NUM_BLOCKS_WIDTH'(1);
                sent_reg  <= sent_reg + NUM_BLOCKS_WIDTH'(1);
                wrap_reg  <= &sync_reg[CNT_WIDTH-1:0];
            end
            // An abort that lands on the final handshake still counts as a clean finish.
            if ((state == ISSUE) && abort && !(hs && last)) begin
                aborted_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_sync_sched.sv
module tb_aes_key_sync_sched;
    localparam int W  = 128;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  cfg_key;
    logic [W-1:0]  cfg_sync;
    logic [NB-1:0] cfg_num_blocks;
    logic          cfg_valid;
    logic          cfg_rdy;
    logic          abort;
    logic [W-1:0]  out_key;
    logic [W-1:0]  out_sync;
    logic          out_valid;
    logic          out_rdy;
    logic          done;
    logic          aborted;
    logic          cnt_wrap;
    logic [NB-1:0] blocks_sent;

    int checks = 0;
    int errors = 0;
    bit pat [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    aes_key_sync_sched #(
        .DATA_WIDTH_IN_BYTES(16),
        .CNT_WIDTH(32),
        .NUM_BLOCKS_WIDTH(NB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_key(cfg_key),
        .cfg_sync(cfg_sync),
        .cfg_num_blocks(cfg_num_blocks),
        .cfg_valid(cfg_valid),
        .cfg_rdy(cfg_rdy),
        .abort(abort),
        .out_key(out_key),
        .out_sync(out_sync),
        .out_valid(out_valid),
        .out_rdy(out_rdy),
        .done(done),
        .aborted(aborted),
        .cnt_wrap(cnt_wrap),
        .blocks_sent(blocks_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: block n of a run carries the initial sync with n added to its low 32-bit word (mod 2^32).
    function automatic logic [W-1:0] exp_sync(input logic [W-1:0] s, input int n);
        logic [31:0] lo;
        lo = s[31:0] + 32'(n);
        return {s[W-1:32], lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [W-1:0] key, input logic [W-1:0] sync, input int num);
        chk({tag, " cfg_rdy_idle"}, W'(cfg_rdy), W'(1));
        cfg_key        = key;
        cfg_sync       = sync;
        cfg_num_blocks = NB'(num);
        cfg_valid      = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Runs from the first cycle after config accept through the cycle after done.
    // mode 0: out_rdy always 1; 1: fixed stall pattern; 2: random. abort_after<0 disables abort.
    task automatic run_body(input string tag, input logic [W-1:0] key, input logic [W-1:0] sync,
                            input int num, input int mode, input int abort_after, input bit abort_rdy);
        int sent;
        int cyc;
        bit ended;
        bit wrap_exp;
        bit ab_exp;
        bit r;
        bit a;
        logic [W-1:0] cur;
        sent = 0;
        cyc = 0;
        ended = (num == 0);
        wrap_exp = 1'b0;
        ab_exp = 1'b0;
        while (!ended && cyc < 100) begin
            cur = exp_sync(sync, sent);
            chk({tag, " out_valid"}, W'(out_valid), W'(1));
            chk({tag, " out_sync"}, out_sync, cur);
            chk({tag, " out_key"}, out_key, key);
            chk({tag, " cnt_wrap"}, W'(cnt_wrap), W'(wrap_exp));
            chk({tag, " done_low"}, W'(done), W'(0));
            chk({tag, " blocks_sent"}, W'(blocks_sent), W'(sent));
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc < 8) ? pat[cyc] : 1'b1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            a = (abort_after >= 0) && (sent == abort_after);
            if (a) r = abort_rdy;
            out_rdy = r;
            abort   = a;
            tick();
            abort   = 1'b0;
            out_rdy = 1'b0;
            wrap_exp = r && (cur[31:0] == 32'hFFFF_FFFF);
            if (r) sent++;
            if (sent == num) begin
                ended = 1'b1;
            end else if (a) begin
                ended = 1'b1;
                ab_exp = 1'b1;
            end
            cyc++;
        end
        if (!ended) chk({tag, " timeout"}, W'(1), W'(0));
        chk({tag, " done"}, W'(done), W'(1));
        chk({tag, " done_valid_low"}, W'(out_valid), W'(0));
        chk({tag, " done_cfg_rdy"}, W'(cfg_rdy), W'(0));
        chk({tag, " aborted"}, W'(aborted), W'(ab_exp));
        chk({tag, " final_blocks"}, W'(blocks_sent), W'(sent));
        chk({tag, " final_wrap"}, W'(cnt_wrap), W'(wrap_exp));
        tick();
        chk({tag, " post_done_low"}, W'(done), W'(0));
        chk({tag, " post_cfg_rdy"}, W'(cfg_rdy), W'(1));
        chk({tag, " post_aborted_hold"}, W'(aborted), W'(ab_exp));
        chk({tag, " post_blocks_hold"}, W'(blocks_sent), W'(sent));
        chk({tag, " post_wrap_low"}, W'(cnt_wrap), W'(0));
    endtask

    initial begin
        logic [W-1:0] k;
        logic [W-1:0] s;
        logic [W-1:0] k2;
        logic [W-1:0] s2;
        int n;
        int ab;

        rst = 1'b1;
        cfg_key = '0;
        cfg_sync = '0;
        cfg_num_blocks = '0;
        cfg_valid = 1'b0;
        abort = 1'b0;
        out_rdy = 1'b0;

        // Reset values visible before any clock edge.
        #2;
        chk("rst out_valid", W'(out_valid), W'(0));
        chk("rst done", W'(done), W'(0));
        chk("rst cfg_rdy", W'(cfg_rdy), W'(1));
        chk("rst aborted", W'(aborted), W'(0));
        chk("rst cnt_wrap", W'(cnt_wrap), W'(0));
        chk("rst blocks_sent", W'(blocks_sent), W'(0));
        chk("rst out_key", out_key, W'(0));
        chk("rst out_sync", out_sync, W'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle cfg_rdy", W'(cfg_rdy), W'(1));
        chk("idle out_valid", W'(out_valid), W'(0));

        // Basic run: low word 5, three blocks, no stalls.
        k = rnd128();
        s = {rnd128() >> 32, 32'h0000_0005};
        start("basic", k, s, 3);
        run_body("basic", k, s, 3, 0, -1, 1'b0);

        // Counter wrap with a fixed nonce.
        k = rnd128();
        s = {{3{32'hA5A5_A5A5}}, 32'hFFFF_FFFE};
        start("wrap", k, s, 3);
        run_body("wrap", k, s, 3, 0, -1, 1'b0);

        // Backpressure pattern 0,1,0,0,1,1,0,1.
        k = rnd128();
        s = rnd128();
        start("bp", k, s, 4);
        run_body("bp", k, s, 4, 1, -1, 1'b0);

        // Abort after two handshakes with out_rdy low.
        k = rnd128();
        s = rnd128();
        start("abort2", k, s, 10);
        run_body("abort2", k, s, 10, 0, 2, 1'b0);

        // Abort coincident with the third handshake.
        k = rnd128();
        s = rnd128();
        start("abort3", k, s, 10);
        run_body("abort3", k, s, 10, 0, 2, 1'b1);

        // Abort coincident with the final handshake is a clean finish.
        k = rnd128();
        s = rnd128();
        start("abort_last", k, s, 3);
        run_body("abort_last", k, s, 3, 0, 2, 1'b1);

        // Zero-length run, then a second config held valid through done.
        k = rnd128();
        s = rnd128();
        k2 = rnd128();
        s2 = rnd128();
        chk("b2b cfg_rdy0", W'(cfg_rdy), W'(1));
        cfg_key = k;
        cfg_sync = s;
        cfg_num_blocks = '0;
        cfg_valid = 1'b1;
        tick();
        cfg_key = k2;
        cfg_sync = s2;
        cfg_num_blocks = NB'(2);
        chk("zero done", W'(done), W'(1));
        chk("zero out_valid", W'(out_valid), W'(0));
        chk("zero cfg_rdy", W'(cfg_rdy), W'(0));
        chk("zero blocks_sent", W'(blocks_sent), W'(0));
        chk("zero aborted", W'(aborted), W'(0));
        tick();
        chk("b2b idle cfg_rdy", W'(cfg_rdy), W'(1));
        chk("b2b idle done", W'(done), W'(0));
        chk("b2b idle out_valid", W'(out_valid), W'(0));
        tick();
        cfg_valid = 1'b0;
        run_body("b2b", k2, s2, 2, 0, -1, 1'b0);

        // Randomized runs, odd ones parked near the counter wrap.
        for (int i = 0; i < 8; i++) begin
            k = rnd128();
            s = rnd128();
            if (i % 2 == 1) s[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            n = $urandom_range(1, 8);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            start("rand", k, s, n);
            run_body("rand", k, s, n, 2, ab, 1'($urandom_range(0, 1)));
        end

        // Reset mid-run: immediate idle, no done pulse.
        k = rnd128();
        s = rnd128();
        start("midrst", k, s, 10);
        out_rdy = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", W'(out_valid), W'(0));
        chk("midrst done", W'(done), W'(0));
        chk("midrst cfg_rdy", W'(cfg_rdy), W'(1));
        chk("midrst blocks_sent", W'(blocks_sent), W'(0));
        chk("midrst out_sync", out_sync, W'(0));
        out_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("midrst post done", W'(done), W'(0));
        chk("midrst post cfg_rdy", W'(cfg_rdy), W'(1));
        chk("midrst post out_valid", W'(out_valid), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
